fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the byte-addressed, combinationally-read instruction memory. It owns the fetch PC, drives the memory read address, and captures returned words with their PCs into a small prefetch buffer. It presents them to decode over a valid/ready handshake and supports redirects (branch/jump flush) from execute. It sits between the instruction memory and the decode stage of the RV32I core.

---
 rtl/fetch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller for the RV32I core. It owns the fetch PC,
// drives the read address of the combinationally-read instruction memory,
// and captures each returned word together with its PC into a small circular
// prefetch buffer. The buffer head is offered to decode over a valid/ready
// handshake. Execute can redirect fetch (branch/jump), which flushes the
// buffer and restarts fetch at the new PC.
//
// Parameters:
//   ADDR_W    byte-address width into instruction memory
//   DEPTH     prefetch buffer entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (4-aligned)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   fetch_en        1 = new fetches may be issued
//   imem_addr       instruction memory read address (always the fetch PC)
//   imem_data       instruction word for imem_addr, same cycle
//   redirect_valid  flush the buffer and restart fetch at redirect_pc
//   redirect_pc     new fetch PC (must be 4-aligned to take effect)
//   out_valid       buffer head holds an instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction word
//   out_pc          byte address of the head instruction
//   misalign_err    sticky flag: a misaligned redirect was seen
//
// Handshake: the head transfers to decode on a rising edge where both
// out_valid and out_ready are 1. out_valid never depends on out_ready, and
// while out_valid is 1 the head (out_instr/out_pc) stays stable until it
// transfers or a redirect flushes it.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              misalign_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    // FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_next;

    logic [ADDR_W-1:0] fetch_pc;

    logic [31:0]       entry_instr [DEPTH];
    logic [ADDR_W-1:0] entry_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Copy of the most recent head, shown while the buffer is empty so the
    // outputs never expose a stale or unwritten slot.
    logic [31:0]       last_instr;
    logic [ADDR_W-1:0] last_pc;

    logic              redirect_ok;
    logic              redirect_bad;
    logic              pop;
    logic              push;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign redirect_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

    assign pop = out_valid & out_ready;

    // A misaligned redirect is ignored outright, so it does not block the
    // push; only an accepted redirect takes priority over fetching. A full
    // buffer still accepts a push when the head leaves in the same cycle.
    assign push = (state == RUN) & fetch_en & ~redirect_ok
                & ((count < FULL_COUNT) | pop);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_en)  state_next = RUN;
            RUN:     if (!fetch_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch PC, pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_RESET;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_ok) begin
            // A pop in this cycle has already been taken by decode; whatever
            // is left in the buffer is on the wrong path and is dropped.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + PC_STEP;   // wraps modulo 2^ADDR_W
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Buffer storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_instr[i] <= '0;
                entry_pc[i]    <= '0;
            end
        end else if (push) begin
            entry_instr[wr_ptr] <= imem_data;
            entry_pc[wr_ptr]    <= fetch_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Last-head holding register and sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_instr <= '0;
            last_pc    <= '0;
        end else if (out_valid) begin
            last_instr <= head_instr;
            last_pc    <= head_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_bad) begin
            misalign_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign head_instr = entry_instr[rd_ptr];
    assign head_pc    = entry_pc[rd_ptr];

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head_instr : last_instr;
    assign out_pc    = out_valid ? head_pc    : last_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl (ADDR_W=7, DEPTH=2, RESET_PC=0). A small
// instruction memory with known contents is modelled here; every expected
// PC and instruction is written out by hand from the stimulus below.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int ADDR_W = 7;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT io
    logic              rst_n;
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              misalign_err;

    fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (2),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    // ---------------------------------------------------------------- memory
    logic [31:0] imem [32];
    assign imem_data = imem[imem_addr[6:2]];

    // Memory contents: two real instructions at 0x00/0x04, then a tagged
    // word carrying its own address everywhere else.
    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] pc);
        if (pc == 7'h00) return 32'h00500093;
        if (pc == 7'h04) return 32'h00A00113;
        return {16'hC0DE, 9'h000, pc};
    endfunction

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled and inputs
    // changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [ADDR_W-1:0] pc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"},    32'(out_pc),    32'(pc));
        check({tag, "_instr"}, out_instr,      word_at(pc));
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        check("rst_valid", 32'(out_valid),    32'd0);
        check("rst_instr", out_instr,         32'd0);
        check("rst_pc",    32'(out_pc),       32'd0);
        check("rst_err",   32'(misalign_err), 32'd0);
        check("rst_addr",  32'(imem_addr),    32'd0);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        for (int i = 0; i < 32; i++) begin
            imem[i] = word_at(ADDR_W'(i * 4));
        end

        // Reset and startup: one idle edge, then one instruction per cycle.
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        check("start_idle_valid", 32'(out_valid), 32'd0);
        check("start_idle_addr",  32'(imem_addr), 32'h00);
        step();
        expect_head("start0", 7'h00);
        check("start0_addr", 32'(imem_addr), 32'h04);
        step();
        expect_head("start1", 7'h04);
        step();
        expect_head("start2", 7'h08);

        // Backpressure: buffer fills with 0x00/0x04, fetch PC holds at 0x08.
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        repeat (5) step();
        expect_head("bp_full", 7'h00);
        check("bp_full_addr", 32'(imem_addr), 32'h08);
        exp_q.push_back(7'h00);
        exp_q.push_back(7'h04);
        exp_q.push_back(7'h08);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_head("bp_drain", exp_q.pop_front());
            step();
        end
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);
        expect_head("bp_next", 7'h0C);

        // Redirect to 0x7C and wrap through the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h7C;
        step();
        redirect_valid = 1'b0;
        check("wrap_flush_valid", 32'(out_valid), 32'd0);
        check("wrap_flush_addr",  32'(imem_addr), 32'h7C);
        step();
        expect_head("wrap0", 7'h7C);
        step();
        expect_head("wrap1", 7'h00);
        step();
        expect_head("wrap2", 7'h04);

        // Fill the buffer at 0x10/0x14, then redirect while popping 0x10.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h10;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        check("fill_flush_valid", 32'(out_valid), 32'd0);
        step();
        expect_head("fill0", 7'h10);
        step();
        step();
        expect_head("fill_full", 7'h10);
        check("fill_full_addr", 32'(imem_addr), 32'h18);
        redirect_valid = 1'b1;
        redirect_pc    = 7'h40;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rdpop_valid", 32'(out_valid), 32'd0);
        check("rdpop_addr",  32'(imem_addr), 32'h40);
        step();
        expect_head("rdpop0", 7'h40);
        step();
        expect_head("rdpop1", 7'h44);

        // Misaligned redirect: ignored, stream continues, error sticks.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h22;
        step();
        redirect_valid = 1'b0;
        expect_head("mis0", 7'h48);
        check("mis0_err",  32'(misalign_err), 32'd1);
        check("mis0_addr", 32'(imem_addr),    32'h4C);
        step();
        expect_head("mis1", 7'h4C);
        check("mis1_err", 32'(misalign_err), 32'd1);

        // fetch_en toggle: fill, drain with fetch disabled, then resume.
        out_ready = 1'b0;
        step();
        step();
        expect_head("fen_full", 7'h4C);
        check("fen_full_addr", 32'(imem_addr), 32'h54);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        step();
        expect_head("fen_drain", 7'h50);
        check("fen_drain_addr", 32'(imem_addr), 32'h54);
        step();
        check("fen_empty_valid", 32'(out_valid), 32'd0);
        check("fen_empty_pc",    32'(out_pc),    32'h50);
        check("fen_empty_instr", out_instr,      word_at(7'h50));
        check("fen_empty_addr",  32'(imem_addr), 32'h54);
        step();
        check("fen_hold_valid", 32'(out_valid), 32'd0);
        check("fen_hold_addr",  32'(imem_addr), 32'h54);
        fetch_en = 1'b1;
        step();
        check("fen_resume_idle", 32'(out_valid), 32'd0);
        step();
        expect_head("fen_resume0", 7'h54);
        step();
        expect_head("fen_resume1", 7'h58);
        check("err_sticky", 32'(misalign_err), 32'd1);

        // Asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid),    32'd0);
        check("arst_pc",    32'(out_pc),       32'd0);
        check("arst_instr", out_instr,         32'd0);
        check("arst_addr",  32'(imem_addr),    32'd0);
        check("arst_err",   32'(misalign_err), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("arst_idle_valid", 32'(out_valid), 32'd0);
        step();
        expect_head("arst_run0", 7'h00);
        step();
        expect_head("arst_run1", 7'h04);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
